// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice.
//   - tx_state_t         : transmitter FSM state encoding
//   - PAR_EVEN / PAR_ODD : values of PAR_TYP
//   - DEFAULT_DATA_WIDTH : default parallel word width
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Request/line bundle between a frame producer and the UART transmitter.
//   P_DATA     : parallel word to send
//   Data_Valid : request, single-cycle or held as a level
//   PAR_EN     : 1 = append a parity bit
//   PAR_TYP    : PAR_EVEN / PAR_ODD
//   TX_OUT     : serial line, idle high
//   busy       : high while a frame is on the line
// Modports: master = producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_WIDTH = uart_pkg::DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Holds the captured data word and the DATA-state bit counter.
//   i_clk   : bit clock
//   i_rst   : synchronous active-low reset (clears word and counter)
//   i_load  : capture i_data, clear the counter
//   i_shift : advance one bit (LSB first)
//   i_data  : parallel word to capture
//   o_bit   : bit currently at the head of the word
//   o_last  : counter is at DATA_WIDTH-1 (final data bit)
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_last
);

  // A one-bit word still needs a one-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shreg <= r_shreg >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_bit  = r_shreg[0];
  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial transmitter: START(0), DATA_WIDTH data bits LSB first, optional
// parity bit, STOP(1). One serial bit per CLK cycle. TX_OUT and busy are
// registered from the current state, so the line lags the FSM by one cycle:
// the start bit appears on the edge after the one that accepts the request.
//   CLK   : bit clock
//   RST   : synchronous active-low reset; aborts any frame, line goes high
//   tx_if : uart_tx_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in;
//           TX_OUT, busy out)
// Build option: define UART_TX_PARITY_EN to include the PARITY state and
// parity register. Without it PAR_EN/PAR_TYP are ignored and every frame
// goes DATA -> STOP.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  tx_if
);

  tx_state_t r_state;
  logic      r_tx;
  logic      r_busy;

  logic w_load;
  logic w_shift;
  logic w_bit;
  logic w_last;

  // Requests are only seen in IDLE; elsewhere Data_Valid is simply dropped.
  assign w_load  = (r_state == IDLE) && tx_if.Data_Valid;
  assign w_shift = (r_state == DATA);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (tx_if.P_DATA),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;
  logic w_par_bit;

  // Parity of the word being captured, so later P_DATA/PAR_TYP changes
  // cannot disturb the frame in flight.
  assign w_par_bit = (tx_if.PAR_TYP == PAR_EVEN) ? (^tx_if.P_DATA)
                                                 : ~(^tx_if.P_DATA);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_load) begin
      r_par_en  <= tx_if.PAR_EN;
      r_par_bit <= w_par_bit;
    end
  end
`else
  logic [1:0] w_unused_par;
  assign w_unused_par = {tx_if.PAR_EN, tx_if.PAR_TYP};
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (tx_if.Data_Valid) r_state <= START;
        end
        START: begin
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= DATA;
        end
        DATA: begin
          r_tx   <= w_bit;
          r_busy <= 1'b1;
          if (w_last) begin
`ifdef UART_TX_PARITY_EN
            r_state <= r_par_en ? PARITY : STOP;
`else
            r_state <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          r_tx    <= r_par_bit;
          r_busy  <= 1'b1;
          r_state <= STOP;
        end
`endif
        STOP: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_if.TX_OUT = r_tx;
  assign tx_if.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx. A line model turns every accepted request into a queue
// of expected line bits (start, data LSB first, optional parity, stop) and
// the line/busy outputs are compared against it every cycle. Directed frames
// additionally compare the captured bit stream against fixed patterns.
// -----------------------------------------------------------------------------
module tb_uart_tx;
  import uart_pkg::*;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_tx #(.DATA_WIDTH(W)) dut (
    .CLK   (clk),
    .RST   (rst),
    .tx_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line model: the transmitter is free exactly when nothing is left queued.
  bit   q[$];
  logic exp_tx   = 1'b1;
  logic exp_busy = 1'b0;
  bit   chk_en   = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else if (q.size() == 0) begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      if (bus.Data_Valid) begin
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(bus.P_DATA[i]);
        if (PAR_BUILT && bus.PAR_EN)
          q.push_back(bit'(($countones(bus.P_DATA) % 2) ^ int'(bus.PAR_TYP)));
        q.push_back(1'b1);
      end
    end else begin
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_line", {31'd0, bus.TX_OUT}, {31'd0, exp_tx});
      check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
    end
  end

  // Single-cycle request issued at a negedge; collects the frame bits and
  // counts busy-high cycles, scrambling the inputs right after capture.
  task automatic run_frame(input logic [W-1:0] d, input logic en, input logic typ,
                           input string tag, input logic [31:0] exp_bits);
    int          len;
    int          nbusy;
    logic [31:0] bits;
    len   = W + 2 + ((PAR_BUILT && en) ? 1 : 0);
    nbusy = 0;
    bits  = '0;
    bus.P_DATA     = d;
    bus.PAR_EN     = en;
    bus.PAR_TYP    = typ;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = W'($urandom);
    bus.PAR_EN     = 1'($urandom);
    bus.PAR_TYP    = 1'($urandom);
    for (int k = 1; k <= len + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (k >= 2 && k <= len + 1) bits = {bits[30:0], bus.TX_OUT};
      if (bus.busy) nbusy++;
    end
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(len));
  endtask

  initial begin
    logic [31:0] bits;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b0;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);

    // Request in the very first cycle after reset release.
    rst = 1'b1;
    run_frame(8'hA5, 1'b1, PAR_EVEN, "even_a5",
              PAR_BUILT ? 32'b01010010101 : 32'b0101001011);
    run_frame(8'hA5, 1'b1, PAR_ODD, "odd_a5",
              PAR_BUILT ? 32'b01010010111 : 32'b0101001011);
    run_frame(8'h3C, 1'b0, PAR_EVEN, "nopar_3c", 32'b0001111001);

    // Held request: three frames, P_DATA changed while each is in flight.
    bits           = '0;
    bus.P_DATA     = 8'h01;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1)  bus.P_DATA = 8'h02;
      if (k == 12) bus.P_DATA = 8'h03;
      if (k == 23) begin
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = W'($urandom);
      end
      if (k >= 2) bits = {bits[30:0], bus.TX_OUT};
    end
    check("b2b_bits", bits, 32'b0100000001_1_0010000001_1_0110000001);
    repeat (2) @(negedge clk);

    // Abort a 0xFF frame while data bit 4 is on the line.
    bus.P_DATA     = 8'hFF;
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_frame_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    run_frame(8'h55, 1'b0, PAR_EVEN, "after_rst_55", 32'b0101010101);

    // Random traffic with occasional resets.
    repeat (800) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 59) != 0);
      bus.Data_Valid = ($urandom_range(0, 3) == 0);
      bus.P_DATA     = W'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.PAR_TYP    = 1'($urandom);
    end
    @(negedge clk);
    rst            = 1'b1;
    bus.Data_Valid = 1'b0;
    repeat (16) @(negedge clk);
    check("final_idle_tx", {31'd0, bus.TX_OUT}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: UART_TX

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 CLK  input  1  transmit bit clock; one serial bit per CLK cycle.
REQ-003 RST  input  1  synchronous, active-low reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-005 Data_Valid  input  1  P_DATA valid request; single-cycle or level.
REQ-006 PAR_EN  input  1  1 inserts a parity bit between data and stop.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 TX_OUT  output  1  serial line; idle high; registered.
REQ-009 busy  output  1  high from the start bit through the stop bit; registered.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-011 In IDLE, TX_OUT = 1 and busy = 0.
REQ-012 In IDLE with Data_Valid = 1 at a CLK edge, the block SHALL capture P_DATA, PAR_EN and PAR_TYP and enter START.
REQ-013 Data_Valid SHALL be ignored in every state other than IDLE; no buffering, no error flag.
REQ-014 P_DATA, PAR_EN and PAR_TYP changes after capture SHALL NOT affect the frame in flight.
REQ-015 START SHALL drive TX_OUT = 0 for exactly 1 cycle.
REQ-016 DATA SHALL drive the captured bits LSB first for exactly DATA_WIDTH cycles.
REQ-017 DATA SHALL use a bit counter of width clog2(DATA_WIDTH). It SHALL leave DATA on the cycle the counter reaches DATA_WIDTH-1.
REQ-018 After DATA, the FSM SHALL go to PARITY if captured PAR_EN = 1, otherwise to STOP.
REQ-019 PARITY SHALL drive the XOR-reduction of the captured data for even parity, or its inverse for odd parity, for 1 cycle.
REQ-020 STOP SHALL drive TX_OUT = 1 for 1 cycle, then the FSM SHALL return to IDLE.
REQ-021 Latency: the first start-bit cycle on TX_OUT SHALL begin at the CLK edge following the accepting edge.
REQ-022 busy SHALL rise on the same edge as the start bit and fall on the edge that ends the stop bit.
REQ-023 Frame length SHALL be DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
REQ-024 Minimum spacing between frames SHALL be one IDLE cycle; Data_Valid held high SHALL therefore produce back-to-back frames separated by exactly one idle-high cycle.
REQ-025 Parity SHALL be computed from the captured word at capture time and held in a register.

Reset
REQ-026 RST = 0 at a CLK edge SHALL force IDLE, TX_OUT = 1, busy = 0, bit counter = 0 and captured data = 0.
REQ-027 RST asserted mid-frame SHALL abort the frame immediately, with the line high on the next edge.
REQ-028 Data_Valid in the first cycle after RST deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro UART_TX_PARITY_EN: when defined, the PARITY state, the parity register and the PAR_EN/PAR_TYP behaviour SHALL be present as above.
REQ-030 When UART_TX_PARITY_EN is undefined:
- PAR_EN and PAR_TYP remain ports but are ignored.
- DATA SHALL always go to STOP.
- No parity logic SHALL be synthesized.

Structure
REQ-031 A shared package uart_pkg SHALL hold:
- the TX state enumeration;
- parity-type constants PAR_EVEN = 0 and PAR_ODD = 1;
- the default DATA_WIDTH constant.
REQ-032 One sub-module, uart_tx_serializer, SHALL contain the data shift register and bit counter. It SHALL be loaded on capture and shifted in DATA. The FSM, parity and output mux remain in UART_TX.

Verification
REQ-033 Even parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, single-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; busy high for exactly 11 cycles.
REQ-034 Odd parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 1 -> parity bit = 1; frame 0,1,0,1,0,0,1,0,1,1,1.
REQ-035 No parity: P_DATA = 0x3C, PAR_EN = 0 -> TX_OUT = 0,0,0,1,1,1,1,0,0,1 over 10 cycles, then idle high.
REQ-036 Data_Valid held high for 3 frames with 0x01, 0x02, 0x03 -> three 10-cycle frames, each separated by exactly one high idle cycle. P_DATA changes mid-frame SHALL not corrupt the frame in flight.
REQ-037 RST = 0 asserted in DATA bit 4 of frame 0xFF -> TX_OUT = 1 and busy = 0 on the next edge. A new Data_Valid with 0x55 after release -> a clean full frame.
REQ-038 Build with UART_TX_PARITY_EN undefined, PAR_EN = 1, P_DATA = 0xA5 -> 10-cycle frame with no parity bit.
